// File: rtl/pipelined_alu_mc.sv
// pipelined_alu_mc: multi-cycle ALU with valid/ready on both sides.
// Single-cycle ops (AND/OR/ADD/SUB/SLT/NOR/reserved) register their result
// on the accept edge. MUL runs an iterative shift-add over WIDTH cycles.
// Result and flags are held stable in DONE until the consumer takes them.
module pipelined_alu_mc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_op,
  input  logic             i_carry_in,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry_out,
  output logic             o_overflow,
  output logic             o_zero,
  output logic             o_negative
);

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_SLT = 3'd4;
  localparam logic [2:0] OP_NOR = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [WIDTH-1:0]     r_result;
  logic                 r_carry;
  logic                 r_ovf;
  logic                 r_zero;
  logic                 r_neg;

  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]     r_cnt;

  // SUB and SLT share the a + ~b + 1 adder path; carry_in only feeds ADD.
  logic                 w_is_sub;
  logic [WIDTH-1:0]     w_b_eff;
  logic                 w_cin_eff;
  logic [WIDTH:0]       w_sum;
  logic                 w_ov;

  assign w_is_sub  = (i_op == OP_SUB) || (i_op == OP_SLT);
  assign w_b_eff   = w_is_sub ? ~i_b : i_b;
  assign w_cin_eff = (i_op == OP_ADD) ? i_carry_in : w_is_sub;
  assign w_sum     = {1'b0, i_a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin_eff};
  assign w_ov      = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);

  logic [WIDTH-1:0]     w_alu_res;
  logic                 w_alu_c;
  logic                 w_alu_v;

  // Single-cycle result/flag selection for everything except MUL.
  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (i_op)
      OP_AND: w_alu_res = i_a & i_b;
      OP_OR:  w_alu_res = i_a | i_b;
      OP_ADD, OP_SUB: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
        w_alu_v   = w_ov;
      end
      OP_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ov};
      OP_NOR: w_alu_res = ~(i_a | i_b);
      default: w_alu_res = '0;
    endcase
  end

  // One shift-add step: the multiplicand is shifted by the iteration index
  // rather than being shifted in place, so it stays WIDTH bits wide.
  logic [2*WIDTH-1:0]   w_addend;
  logic [2*WIDTH-1:0]   w_acc_step;
  logic                 w_last;

  assign w_addend   = {{WIDTH{1'b0}}, r_mcand} << r_cnt;
  assign w_acc_step = r_mplier[0] ? (r_acc + w_addend) : r_acc;
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  // Next-state decode for IDLE -> (DONE | MUL) -> DONE -> IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (i_in_valid) w_state_next = (i_op == OP_MUL) ? S_MUL : S_DONE;
      S_MUL:  if (w_last) w_state_next = S_DONE;
      S_DONE: if (i_out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Datapath: load single-cycle results on accept, iterate the multiplier,
  // and hold everything untouched while waiting in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            if (i_op == OP_MUL) begin
              r_mcand  <= i_a;
              r_mplier <= i_b;
              r_acc    <= '0;
              r_cnt    <= '0;
            end else begin
              r_result <= w_alu_res;
              r_carry  <= w_alu_c;
              r_ovf    <= w_alu_v;
              r_zero   <= (w_alu_res == '0);
              r_neg    <= w_alu_res[WIDTH-1];
            end
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_step;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_result <= w_acc_step[WIDTH-1:0];
            r_carry  <= 1'b0;
            r_ovf    <= |w_acc_step[2*WIDTH-1:WIDTH];
            r_zero   <= (w_acc_step[WIDTH-1:0] == '0);
            r_neg    <= w_acc_step[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign o_in_ready  = (r_state == S_IDLE);
  assign o_out_valid = (r_state == S_DONE);
  assign o_result    = r_result;
  assign o_carry_out = r_carry;
  assign o_overflow  = r_ovf;
  assign o_zero      = r_zero;
  assign o_negative  = r_neg;

endmodule

// File: tb/tb_pipelined_alu_mc.sv
// Testbench for pipelined_alu_mc: directed spec vectors plus randomized ops
// checked against a plain-arithmetic reference model.
module tb_pipelined_alu_mc;
  localparam int W  = 32;
  localparam int CW = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_in_valid = 1'b0;
  logic         o_in_ready;
  logic [W-1:0] i_a = '0;
  logic [W-1:0] i_b = '0;
  logic [2:0]   i_op = '0;
  logic         i_carry_in = 1'b0;
  logic         o_out_valid;
  logic         i_out_ready = 1'b1;
  logic [W-1:0] o_result;
  logic         o_carry_out, o_overflow, o_zero, o_negative;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
    logic         n;
  } exp_t;

  pipelined_alu_mc #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_a(i_a), .i_b(i_b), .i_op(i_op), .i_carry_in(i_carry_in),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_result(o_result), .o_carry_out(o_carry_out), .o_overflow(o_overflow),
    .o_zero(o_zero), .o_negative(o_negative)
  );

  always #5 clk = ~clk;

  // Reference model: integer arithmetic on 64-bit values.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] op, input logic cin);
    exp_t e;
    longint sa, sb, ss, hi, lo;
    longint unsigned ua, ub, us;
    logic [2*W-1:0] p;
    e  = '0;
    hi = (longint'(1) <<< (W - 1)) - 1;
    lo = -(longint'(1) <<< (W - 1));
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    case (op)
      3'd0: e.res = a & b;
      3'd1: e.res = a | b;
      3'd2: begin
        us = ua + ub + 64'(cin);
        e.res = us[W-1:0];
        e.c = (us >> W) != 0;
        ss = sa + sb + longint'(cin);
        e.v = (ss > hi) || (ss < lo);
      end
      3'd3: begin
        e.res = a - b;
        e.c = (a >= b);
        ss = sa - sb;
        e.v = (ss > hi) || (ss < lo);
      end
      3'd4: e.res = {{(W-1){1'b0}}, (sa < sb)};
      3'd5: e.res = ~(a | b);
      3'd6: begin
        p = 64'(a) * 64'(b);
        e.res = p[W-1:0];
        e.v = |p[2*W-1:W];
      end
      default: e.res = '0;
    endcase
    e.z = (e.res == '0);
    e.n = e.res[W-1];
    return e;
  endfunction

  function automatic exp_t observed();
    return {o_result, o_carry_out, o_overflow, o_zero, o_negative};
  endfunction

  // Present one op at a negedge, wait for the accept edge, then count cycles
  // until out_valid is seen (bounded). Called at a negedge with the DUT idle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, input logic cin, output int lat);
    i_a = a; i_b = b; i_op = op; i_carry_in = cin; i_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_in_valid = 1'b0;
    lat = 1;
    while (!o_out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic retire();
    i_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: got in_ready=%b out_valid=%b want 1/0", o_in_ready, o_out_valid);
    end
    checks++;
    if (observed() !== exp_t'(0)) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", observed());
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alu_ops();
    logic [W-1:0] ta [14];
    logic [W-1:0] tb [14];
    logic [2:0]   top [14];
    logic         tc [14];
    logic [W-1:0] tr [14];
    logic [3:0]   tf [14];
    int lat;
    ta  = '{32'hB, 32'hB, 32'hB, 32'hB, 32'hC, 32'hFFFFFFFF, 32'h7FFFFFFF,
            32'hFFFFFFFF, 32'h5, 32'h12345678, 32'h5, 32'h1, 32'h80000000, 32'h3};
    tb  = '{32'hC, 32'hC, 32'hC, 32'hC, 32'hB, 32'h1, 32'h1,
            32'h0, 32'h6, 32'h9ABCDEF0, 32'h5, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h4};
    top = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd2, 3'd2, 3'd5, 3'd7, 3'd3, 3'd4, 3'd4, 3'd2};
    tc  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tr  = '{32'h8, 32'hF, 32'h17, 32'hFFFFFFFF, 32'h1, 32'h1, 32'h80000000,
            32'h0, 32'hFFFFFFF8, 32'h0, 32'h0, 32'h0, 32'h1, 32'h8};
    // flags {carry, overflow, zero, negative}
    tf  = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b1000, 4'b0000, 4'b0101,
            4'b1010, 4'b0001, 4'b0010, 4'b1010, 4'b0010, 4'b0000, 4'b0000};
    i_out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      run_op(ta[i], tb[i], top[i], tc[i], lat);
      $display("txn alu[%0d] op=%0d a=%h b=%h -> %h lat=%0d", i, top[i], ta[i], tb[i], o_result, lat);
      checks++;
      if (lat != 1) begin
        errors++;
        $display("FAIL alu_latency[%0d]: got %0d want 1", i, lat);
      end
      checks++;
      if (o_result !== tr[i] || {o_carry_out, o_overflow, o_zero, o_negative} !== tf[i]) begin
        errors++;
        $display("FAIL alu_value[%0d]: got %h/%b want %h/%b", i, o_result,
                 {o_carry_out, o_overflow, o_zero, o_negative}, tr[i], tf[i]);
      end
      retire();
      checks++;
      if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL alu_retire[%0d]: got in_ready=%b out_valid=%b want 1/0", i, o_in_ready, o_out_valid);
      end
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] ta [6];
    logic [W-1:0] tb [6];
    logic [W-1:0] tr [6];
    logic [3:0]   tf [6];
    int lat;
    ta = '{32'h1234, 32'h10000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 32'h7};
    tb = '{32'h10, 32'h10000, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h2, 32'hFFFFFFFF};
    tr = '{32'h12340, 32'h0, 32'h1, 32'h0, 32'h0, 32'hFFFFFFF9};
    tf = '{4'b0000, 4'b0110, 4'b0100, 4'b0010, 4'b0110, 4'b0101};
    i_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run_op(ta[i], tb[i], 3'd6, 1'b0, lat);
      $display("txn mul[%0d] a=%h b=%h -> %h ov=%b lat=%0d", i, ta[i], tb[i], o_result, o_overflow, lat);
      checks++;
      if (lat != W + 1) begin
        errors++;
        $display("FAIL mul_latency[%0d]: got %0d want %0d", i, lat, W + 1);
      end
      checks++;
      if (o_result !== tr[i] || {o_carry_out, o_overflow, o_zero, o_negative} !== tf[i]) begin
        errors++;
        $display("FAIL mul_value[%0d]: got %h/%b want %h/%b", i, o_result,
                 {o_carry_out, o_overflow, o_zero, o_negative}, tr[i], tf[i]);
      end
      retire();
    end
  endtask

  task automatic test_backpressure();
    exp_t snap, want;
    int lat;
    i_out_ready = 1'b0;
    run_op(32'h7FFFFFF0, 32'h00000123, 3'd2, 1'b1, lat);
    snap = observed();
    want = model(32'h7FFFFFF0, 32'h00000123, 3'd2, 1'b1);
    $display("txn bp first -> %h lat=%0d", o_result, lat);
    checks++;
    if (lat != 1 || snap !== want) begin
      errors++;
      $display("FAIL bp_first: got %h lat=%0d want %h lat=1", snap, lat, want);
    end
    // Offer a new op while stalled; it must not disturb the held result.
    i_a = 32'hA5A5A5A5; i_b = 32'h0F0F0F0F; i_op = 3'd1; i_carry_in = 1'b0; i_in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (observed() !== snap || o_in_ready !== 1'b0 || o_out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got %h rdy=%b vld=%b want %h rdy=0 vld=1",
                 c, observed(), o_in_ready, o_out_valid, snap);
      end
    end
    i_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_retire: got rdy=%b vld=%b want 1/0", o_in_ready, o_out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    i_in_valid = 1'b0;
    want = model(32'hA5A5A5A5, 32'h0F0F0F0F, 3'd1, 1'b0);
    $display("txn bp second -> %h", o_result);
    checks++;
    if (o_out_valid !== 1'b1 || observed() !== want) begin
      errors++;
      $display("FAIL bp_next: got vld=%b %h want vld=1 %h", o_out_valid, observed(), want);
    end
    retire();
  endtask

  task automatic test_reset_mid_mul();
    int seen, lat;
    exp_t want;
    i_out_ready = 1'b1;
    i_a = 32'hDEADBEEF; i_b = 32'h12345678; i_op = 3'd6; i_carry_in = 1'b0; i_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_in_valid = 1'b0;
    repeat (14) @(negedge clk);
    checks++;
    if (o_in_ready !== 1'b0 || o_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_mul_busy: got rdy=%b vld=%b want 0/0", o_in_ready, o_out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0 || observed() !== exp_t'(0)) begin
      errors++;
      $display("FAIL mid_mul_reset: got rdy=%b vld=%b out=%h want 1/0/0", o_in_ready, o_out_valid, observed());
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (W + 5) begin
      @(negedge clk);
      if (o_out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL mid_mul_stale: got %0d valid cycles want 0", seen);
    end
    run_op(32'd2, 32'd3, 3'd2, 1'b0, lat);
    want = model(32'd2, 32'd3, 3'd2, 1'b0);
    $display("txn after reset ADD 2+3 -> %h lat=%0d", o_result, lat);
    checks++;
    if (lat != 1 || o_result !== 32'd5 || observed() !== want) begin
      errors++;
      $display("FAIL post_reset_add: got %h lat=%0d want 5 lat=1", o_result, lat);
    end
    retire();
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [W-1:0] a, b;
    logic [2:0]   op;
    logic         cin;
    exp_t want;
    int lat, stall;
    for (int i = 0; i < 40; i++) begin
      a = pick_operand();
      b = pick_operand();
      op = 3'($urandom_range(0, 7));
      cin = 1'($urandom_range(0, 1));
      stall = $urandom_range(0, 3);
      want = model(a, b, op, cin);
      i_out_ready = (stall == 0);
      run_op(a, b, op, cin, lat);
      $display("txn rnd[%0d] op=%0d a=%h b=%h cin=%b -> %h flags=%b lat=%0d", i, op, a, b, cin,
               o_result, {o_carry_out, o_overflow, o_zero, o_negative}, lat);
      checks++;
      if (lat != ((op == 3'd6) ? W + 1 : 1)) begin
        errors++;
        $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, lat, (op == 3'd6) ? W + 1 : 1);
      end
      repeat (stall) @(negedge clk);
      checks++;
      if (observed() !== want || o_out_valid !== 1'b1) begin
        errors++;
        $display("FAIL rnd_value[%0d]: got %h vld=%b want %h", i, observed(), o_out_valid, want);
      end
      retire();
      checks++;
      if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rnd_retire[%0d]: got rdy=%b vld=%b want 1/0", i, o_in_ready, o_out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
